// File: rtl/lcd_pkg.sv
// lcd_pkg: shared encodings and command constants for the character-LCD frame writer
package lcd_pkg;
  localparam int CW = 24;
  typedef enum logic [2:0] {PWR_WAIT, INIT, CFG, IDLE, FRAME} st_t;
  typedef enum logic [1:0] {NIDLE, SETUP, EHIGH, HOLD} nst_t;
  localparam logic [7:0] ROW0 = 8'h80;
  localparam logic [7:0] ROW1 = 8'hC0;
  function automatic logic [3:0] init_nib(input logic [1:0] i);
    return i == 2'd3 ? 4'h2 : 4'h3;
  endfunction
  function automatic logic [7:0] cfg_byte(input logic [1:0] i);
    return i == 2'd0 ? 8'h28 : i == 2'd1 ? 8'h06 : i == 2'd2 ? 8'h0C : 8'h01;
  endfunction
endpackage

// File: rtl/lcd_nibble_tx.sv
// lcd_nibble_tx: sends one nibble or one byte (upper then lower) on the 4-bit LCD bus, then holds for a post-wait
// i_start latches i_data/i_rs/i_two/i_wait while o_ready; o_done pulses in the final hold cycle;
// o_sf_d/o_e/o_rs drive the LCD pins. Single-nibble mode sends i_data[3:0].
module lcd_nibble_tx import lcd_pkg::*; #(
  parameter int T_E = 12,
  parameter int T_SU = 2,
  parameter int T_NIB = 50
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic [7:0]    i_data,
  input  logic          i_rs,
  input  logic          i_two,
  input  logic [CW-1:0] i_wait,
  output logic          o_ready,
  output logic          o_done,
  output logic [3:0]    o_sf_d,
  output logic          o_e,
  output logic          o_rs
);
  nst_t r_st, w_nxt;
  logic [CW-1:0] r_cnt, r_wait;
  logic [3:0] r_nib, r_lo_nib;
  logic r_lo, r_rs, w_zero;
  assign w_zero = r_cnt == '0;
  assign o_ready = r_st == NIDLE;
  assign o_done = r_st == HOLD && w_zero && r_lo;
  assign o_e = r_st == EHIGH;
  assign o_sf_d = r_nib;
  assign o_rs = r_rs;
  always_comb begin
    w_nxt = r_st == NIDLE ? (i_start ? SETUP : NIDLE) : !w_zero ? r_st :
            r_st == SETUP ? EHIGH : r_st == EHIGH ? HOLD : r_lo ? NIDLE : SETUP;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st <= NIDLE;
      r_cnt <= '0;
      r_wait <= '0;
      r_nib <= '0;
      r_lo_nib <= '0;
      r_lo <= 1'b0;
      r_rs <= 1'b0;
    end else begin
      r_st <= w_nxt;
      if (r_st == NIDLE && i_start) begin
        r_nib <= i_two ? i_data[7:4] : i_data[3:0];
        r_lo_nib <= i_data[3:0];
        r_rs <= i_rs;
        r_lo <= !i_two;
        r_wait <= i_wait;
        r_cnt <= CW'(T_SU - 1);
      end else if (!w_zero) r_cnt <= r_cnt - 1'b1;
      else if (r_st == SETUP) r_cnt <= CW'(T_E - 1);
      else if (r_st == EHIGH) r_cnt <= r_lo ? r_wait - 1'b1 : CW'(T_NIB - 1);
      else if (r_st == HOLD && !r_lo) begin
        r_lo <= 1'b1;
        r_nib <= r_lo_nib;
        r_cnt <= CW'(T_SU - 1);
      end
    end
  end
endmodule

// File: rtl/lcd_frame_writer.sv
// lcd_frame_writer: 2x16 character buffer that initialises an HD44780 and streams the buffer on repaint
// dat/addr/we write the buffer at any time; repaint requests a full frame; busy is low only in IDLE;
// SF_D/LCD_E/LCD_RS are the 4-bit LCD bus.
module lcd_frame_writer import lcd_pkg::*; #(
  parameter int T_PWRUP = 750000,
  parameter int T_E = 12,
  parameter int T_SU = 2,
  parameter int T_NIB = 50,
  parameter int T_CMD = 2000,
  parameter int T_CLR = 82000,
  parameter int T_INIT1 = 205000,
  parameter int T_INIT2 = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dat,
  input  logic [4:0] addr,
  input  logic       we,
  input  logic       repaint,
  output logic       busy,
  output logic [3:0] SF_D,
  output logic       LCD_E,
  output logic       LCD_RS
);
  logic [7:0] r_buf [32] = '{default: 8'h20};
  st_t r_st, w_nxt;
  logic [5:0] r_idx;
  logic [CW-1:0] r_cnt, w_wait;
  logic [7:0] w_data;
  logic [4:0] w_bidx;
  logic r_pend, w_ready, w_done, w_start, w_two, w_rs, w_last, w_again;
  always_ff @(posedge clk) if (we) r_buf[addr] <= dat;
  assign busy = r_st != IDLE;
  assign w_start = w_ready && (r_st == INIT || r_st == CFG || r_st == FRAME);
  assign w_last = r_st == FRAME ? r_idx == 6'd33 : r_idx == 6'd3;
  // a repaint in the very cycle a frame (or CFG) ends is folded into the restart decision
  assign w_again = r_pend || repaint;
  // frame items: 0 = row-0 address, 1..16 = buf[0..15], 17 = row-1 address, 18..33 = buf[16..31]
  assign w_bidx = r_idx <= 6'd16 ? 5'(r_idx - 6'd1) : 5'(r_idx - 6'd2);
  always_comb begin
    w_two = r_st != INIT;
    w_rs = r_st == FRAME && r_idx != 6'd0 && r_idx != 6'd17;
    w_data = r_st == INIT ? {4'h0, init_nib(r_idx[1:0])} : r_st == CFG ? cfg_byte(r_idx[1:0]) :
             r_idx == 6'd0 ? ROW0 : r_idx == 6'd17 ? ROW1 : r_buf[w_bidx];
    w_wait = r_st == INIT && r_idx == 6'd0 ? CW'(T_INIT1) : r_st == INIT && r_idx == 6'd1 ? CW'(T_INIT2) :
             r_st == CFG && r_idx == 6'd3 ? CW'(T_CLR) : CW'(T_CMD);
  end
  always_comb begin
    w_nxt = r_st;
    case (r_st)
      PWR_WAIT:   if (r_cnt == CW'(T_PWRUP - 1)) w_nxt = INIT;
      INIT:       if (w_done && w_last) w_nxt = CFG;
      CFG, FRAME: if (w_done && w_last) w_nxt = w_again ? FRAME : IDLE;
      IDLE:       if (repaint) w_nxt = FRAME;
      default:    w_nxt = PWR_WAIT;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_st <= PWR_WAIT;
      r_idx <= '0;
      r_cnt <= '0;
      r_pend <= 1'b0;
    end else begin
      r_st <= w_nxt;
      r_cnt <= r_st == PWR_WAIT ? r_cnt + 1'b1 : '0;
      if (w_done) r_idx <= w_last ? 6'd0 : r_idx + 6'd1;
      r_pend <= (w_done && w_last && w_nxt == FRAME) ? 1'b0 : (repaint && r_st != IDLE) ? 1'b1 : r_pend;
    end
  end
  lcd_nibble_tx #(.T_E(T_E), .T_SU(T_SU), .T_NIB(T_NIB)) u_tx (
    .clk(clk), .rst(rst), .i_start(w_start), .i_data(w_data), .i_rs(w_rs), .i_two(w_two),
    .i_wait(w_wait), .o_ready(w_ready), .o_done(w_done), .o_sf_d(SF_D), .o_e(LCD_E), .o_rs(LCD_RS)
  );
endmodule

// File: tb/tb_lcd_frame_writer.sv
// tb_lcd_frame_writer: directed and randomized checks of the LCD frame writer against a pulse-level bus model
module tb_lcd_frame_writer;
  localparam int PW = 20, I1 = 8, I2 = 6, CM = 5, CL = 9, NB = 3, TE = 2, SU = 1;
  localparam int ITEM = 2 * (SU + TE) + NB + CM + 1;
  localparam int FRAME_CYC = 34 * ITEM;
  localparam int INIT_CYC = PW + (1 + SU + TE + I1) + (1 + SU + TE + I2) + 2 * (1 + SU + TE + CM)
                          + 3 * ITEM + (ITEM - CM + CL);
  logic clk = 0, rst = 1, we = 0, repaint = 0, busy, LCD_E, LCD_RS;
  logic [7:0] dat = 0;
  logic [4:0] addr = 0;
  logic [3:0] SF_D;
  always #5 clk = ~clk;
  lcd_frame_writer #(.T_PWRUP(PW), .T_E(TE), .T_SU(SU), .T_NIB(NB), .T_CMD(CM), .T_CLR(CL),
    .T_INIT1(I1), .T_INIT2(I2)) dut (
    .clk(clk), .rst(rst), .dat(dat), .addr(addr), .we(we), .repaint(repaint), .busy(busy),
    .SF_D(SF_D), .LCD_E(LCD_E), .LCD_RS(LCD_RS));

  typedef struct {logic [3:0] n; logic rs; int w; bit ok;} pulse_t;
  pulse_t q[$];
  pulse_t cur;
  logic pe = 0, prs = 0;
  logic [3:0] psd = 0;
  int tests = 0, fails = 0;
  logic [7:0] mbuf [32];
  logic [7:0] sbuf [32];
  logic [3:0] init_exp [12] = '{4'h3, 4'h3, 4'h3, 4'h2, 4'h2, 4'h8, 4'h0, 4'h6, 4'h0, 4'hC, 4'h0, 4'h1};

  // bus monitor: one record per E pulse with nibble, RS, width and setup/hold stability
  always @(negedge clk) begin
    if (LCD_E && !pe) begin
      cur.n = SF_D; cur.rs = LCD_RS; cur.w = 0; cur.ok = (psd === SF_D) && (prs === LCD_RS);
    end
    if (LCD_E) begin
      cur.w++;
      if (SF_D !== cur.n || LCD_RS !== cur.rs) cur.ok = 0;
    end else if (pe) q.push_back(cur);
    pe = LCD_E; psd = SF_D; prs = LCD_RS;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    we = 1; addr = 5'(a); dat = d;
    tick;
    we = 0;
    mbuf[a] = d;
  endtask

  task automatic pulse_rep;
    repaint = 1;
    tick;
    repaint = 0;
  endtask

  task automatic wait_idle(input int r0, input int r1, input int r2, output int n);
    n = 0;
    while (busy && n < 5000) begin
      repaint = (n == r0 || n == r1 || n == r2);
      tick;
      n++;
    end
    repaint = 0;
  endtask

  task automatic snap;
    for (int i = 0; i < 32; i++) sbuf[i] = mbuf[i];
  endtask

  task automatic check_init(input string tag);
    int bad = 0;
    chk({tag, "_len"}, q.size() >= 12, 1);
    for (int i = 0; i < 12 && i < q.size(); i++) begin
      chk($sformatf("%s_nib%0d", tag, i), q[i].n, init_exp[i]);
      if (q[i].rs !== 1'b0 || q[i].w != TE || !q[i].ok) bad++;
    end
    chk({tag, "_pulses"}, bad, 0);
  endtask

  // expected frame: row-0 address, buffer 0..15 as data, row-1 address, buffer 16..31 as data
  task automatic check_frame(input int base, input string tag);
    logic [7:0] eb [34];
    int bad = 0, rs1 = 0;
    eb[0] = 8'h80; eb[17] = 8'hC0;
    for (int i = 0; i < 16; i++) begin eb[1 + i] = sbuf[i]; eb[18 + i] = sbuf[16 + i]; end
    chk({tag, "_len"}, q.size() >= base + 68, 1);
    if (q.size() >= base + 68) begin
      for (int k = 0; k < 34; k++) begin
        chk($sformatf("%s_b%0d", tag, k), {q[base + 2 * k].n, q[base + 2 * k + 1].n}, eb[k]);
        if (q[base + 2 * k].rs !== q[base + 2 * k + 1].rs || q[base + 2 * k].rs !== (k != 0 && k != 17)) bad++;
      end
      for (int i = base; i < base + 68; i++) begin
        if (q[i].w != TE || !q[i].ok) bad++;
        if (q[i].rs === 1'b1) rs1++;
      end
    end
    chk({tag, "_rs1"}, rs1, 64);
    chk({tag, "_pulses"}, bad, 0);
  endtask

  initial begin
    int n, k, bh;
    string s = "Hello";
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
    repeat (3) tick;
    chk("rst_sfd", SF_D, 0);
    chk("rst_e", LCD_E, 0);
    chk("rst_rs", LCD_RS, 0);
    chk("rst_busy", busy, 1);
    rst = 0;
    wait_idle(-1, -1, -1, n);
    chk("init_cycles", n, INIT_CYC);
    chk("init_count", q.size(), 12);
    check_init("init");
    bh = 0;
    repeat (30) begin tick; if (busy !== 1'b0) bh++; end
    chk("idle_stays", bh, 0);

    q.delete();
    for (int i = 0; i < 5; i++) wr(i, s[i]);
    wr(31, 8'h58);
    repeat (6) wr($urandom_range(5, 30), 8'($urandom_range(33, 126)));
    snap;
    chk("pre_busy", busy, 0);
    pulse_rep;
    chk("busy_rise", busy, 1);
    wait_idle(-1, -1, -1, n);
    chk("frame_cycles", n, FRAME_CYC);
    chk("frame_count", q.size(), 68);
    check_frame(0, "hello");

    q.delete();
    snap;
    pulse_rep;
    wait_idle(40, 140, 190, n);
    chk("merge_cycles", n, 2 * FRAME_CYC);
    chk("merge_count", q.size(), 136);
    check_frame(0, "merge_a");
    check_frame(68, "merge_b");

    q.delete();
    pulse_rep;
    k = 0;
    while (q.size() < 21 && k < 2000) begin tick; k++; end
    chk("mid_reached", q.size() >= 21, 1);
    wr(20, 8'h51);
    snap;
    wr(2, 8'h5A);
    pulse_rep;
    wait_idle(-1, -1, -1, n);
    chk("mid_count", q.size(), 136);
    check_frame(0, "mid_q");
    snap;
    check_frame(68, "mid_z");

    q.delete();
    pulse_rep;
    repeat (5) tick;
    pulse_rep;
    k = 0;
    while (!(q.size() >= 35 && LCD_E) && k < 2000) begin tick; k++; end
    chk("item17_e", LCD_E, 1);
    rst = 1;
    #1;
    chk("abort_sfd", SF_D, 0);
    chk("abort_e", LCD_E, 0);
    chk("abort_rs", LCD_RS, 0);
    chk("abort_busy", busy, 1);
    repeat (2) tick;
    q.delete();
    rst = 0;
    wait_idle(-1, -1, -1, n);
    chk("reinit_cycles", n, INIT_CYC);
    check_init("reinit");
    bh = 0;
    repeat (40) begin tick; if (busy !== 1'b0) bh++; end
    chk("reinit_idle", bh, 0);
    chk("reinit_no_frame", q.size(), 12);

    rst = 1;
    repeat (2) tick;
    q.delete();
    rst = 0;
    wait_idle(3, -1, -1, n);
    chk("pw_cycles", n, INIT_CYC + FRAME_CYC);
    chk("pw_count", q.size(), 80);
    check_init("pw_init");
    snap;
    check_frame(12, "pw_frame");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/lcd_frame_writer.md
Name: lcd_frame_writer

Overview:
Character-LCD driver that sits directly downstream of the UI block and receives its dat/addr/we/repaint stream. It holds a 32-character frame buffer (2 rows x 16) and runs the HD44780 power-up initialisation over the 4-bit SF_D bus. On each repaint request it streams the whole buffer to the display. busy tells the UI when a transfer is in progress.

Parameters:
T_PWRUP, 750000, cycles of power-up wait before the first nibble (15 ms at 50 MHz)
T_E, 12, cycles LCD_E is held high per nibble
T_SU, 2, cycles RS/SF_D are stable before LCD_E rises
T_NIB, 50, gap in cycles between the upper and lower nibble of a byte
T_CMD, 2000, post-byte wait in cycles for normal commands and data (40 us)
T_CLR, 82000, post-byte wait in cycles after the Clear command (1.64 ms)
T_INIT1, 205000, wait in cycles after the first init nibble (4.1 ms)
T_INIT2, 5000, wait in cycles after the second init nibble (100 us)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
dat  in  8  character code to write into the buffer
addr  in  5  buffer index; 0-15 is row 0, 16-31 is row 1
we  in  1  writes dat to buf[addr] on this clock edge
repaint  in  1  single-cycle request to send the buffer to the LCD
busy  out  1  high during init or during a frame transfer
SF_D  out  4  LCD data nibble
LCD_E  out  1  LCD enable strobe
LCD_RS  out  1  register select; 0 = command, 1 = data

Behaviour:
- Reset, asynchronous and active-high. Outputs go to SF_D=0, LCD_E=0, LCD_RS=0, busy=1. The FSM goes to PWR_WAIT, the pending flag clears and all counters clear.
- Reset asserted mid-transfer aborts the transfer immediately. After release the full init sequence runs again.
- Buffer contents are not touched by rst. At configuration every buffer location holds 0x20 (space).
- Buffer writes:
  - Accepted on any cycle, in every state, independent of busy.
  - A byte is read from the buffer in the cycle its upper nibble enters SETUP. A write before that cycle is displayed in the current frame; a later write appears in the next frame.
- Top-level FSM:
  - PWR_WAIT: wait T_PWRUP cycles, then go to INIT.
  - INIT: send single nibbles 0x3, 0x3, 0x3, 0x2 with RS=0. The waits after them are T_INIT1, T_INIT2, T_CMD and T_CMD.
  - CFG: send full bytes 0x28, 0x06, 0x0C, 0x01 with RS=0. The first three wait T_CMD; 0x01 waits T_CLR.
  - IDLE: busy=0.
  - FRAME: send 34 items in this order:
    - command 0x80;
    - buf[0..15] with RS=1;
    - command 0xC0;
    - buf[16..31] with RS=1.
    After each item wait T_CMD, then go to IDLE, or restart FRAME if a repaint is pending.
- Repaint handling:
  - repaint in IDLE moves to FRAME on the next cycle, and busy rises in that same cycle.
  - repaint in any other state sets the pending flag. Multiple requests merge into one.
  - A pending flag set during PWR_WAIT, INIT or CFG is serviced straight after CFG, without passing through IDLE.
  - repaint arriving in the same cycle the FSM leaves FRAME counts as pending.
- Nibble timing: SETUP (T_SU cycles, RS/SF_D valid, E=0), then EHIGH (T_E cycles, E=1), then HOLD.
  - Within a byte: upper nibble, HOLD of T_NIB, lower nibble, then HOLD of the item's post-wait.
  - SF_D and RS stay stable from SETUP through the end of EHIGH.
  - LCD_E is never high for more or fewer than T_E cycles.
- The frame index counts 0-33 and stops at the end of the frame; it does not wrap. Buffer addr is 5 bits, so any addr value is legal.
- LCD_RS=1 only for buffer-data items.
- Each frame takes (34 x (2 x (T_SU + T_E) + T_NIB + T_CMD)) cycles, plus one cycle per item for the state change.

Decomposition:
- Package lcd_pkg:
  - init nibble values;
  - cfg command bytes (0x28, 0x06, 0x0C, 0x01);
  - DDRAM row bases (0x80, 0xC0);
  - state enum encodings (PWR_WAIT, INIT, CFG, IDLE, FRAME);
  - nibble-FSM encodings (SETUP, EHIGH, HOLD).
- Sub-module lcd_nibble_tx:
  - inputs: start, nib[3:0], rs, two_nib/byte mode, post-wait count;
  - outputs: done pulse and the SF_D/LCD_E/LCD_RS drive;
  - owns the timing counter.
  The parent owns the sequencing, the buffer (distributed RAM) and the pending logic.

Test Plan:
Use small sim overrides: T_PWRUP=20, T_INIT1=8, T_INIT2=6, T_CMD=5, T_CLR=9, T_NIB=3, T_E=2, T_SU=1.
- Reset release with no activity: observed E pulses carry nibble sequence 3,3,3,2,2,8,0,6,0,C,0,1. Every E pulse is 2 cycles wide with RS=0. busy then falls to 0 and stays 0.
- Write "Hello" to addr 0-4 and 'X' to addr 31, then pulse repaint in IDLE:
  - 68 E pulses;
  - the byte sequence decodes to 0x80, "Hello", eleven 0x20, 0xC0, fifteen 0x20, 'X';
  - RS=1 on exactly 64 pulses;
  - busy rises the cycle after repaint and falls after the last wait.
- repaint pulsed three times during a frame: exactly one extra frame follows; busy stays high throughout, then drops.
- Write addr 20 = 'Q' mid-frame while byte 10 is in flight: 'Q' appears in this frame. Write addr 2 = 'Z' at the same point: it appears only in the next frame.
- rst asserted during the frame at item 17: SF_D/E/RS go to 0 asynchronously and busy=1. After release the full init sequence repeats, the pending flag is clear and the FSM reaches IDLE with no frame sent.
- repaint pulsed during PWR_WAIT: a frame starts immediately after 0x01 plus T_CLR, with no IDLE cycle at busy=0 in between.
